// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//
// Groups the per-frame sequencer's datapath and VGA-facing signals.
//
//   master (sequencer side)
//     out player_move, move_dir  : player move strobe and direction (1 = right)
//     out shift_en, spawn_en     : playfield shift / spawn-buffer load strobes
//     out rd_col, rd_row         : playfield read address
//     out plot, x, y, colour     : VGA adapter plot write port
//     in  cell_bit               : playfield bit for last cycle's read address
//     in  collide                : player/obstacle overlap flag
//   slave (datapath / VGA side): the same signals with directions reversed.
interface game_sequencer_if #(
  parameter int COLS = 16,
  parameter int ROWS = 32
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic             player_move;
  logic             move_dir;
  logic             shift_en;
  logic             spawn_en;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic             cell_bit;
  logic             collide;
  logic             plot;
  logic [COL_W-1:0] x;
  logic [ROW_W-1:0] y;
  logic [2:0]       colour;

  modport master (
    output player_move, move_dir, shift_en, spawn_en,
    output rd_col, rd_row,
    output plot, x, y, colour,
    input  cell_bit, collide
  );

  modport slave (
    input  player_move, move_dir, shift_en, spawn_en,
    input  rd_col, rd_row,
    input  plot, x, y, colour,
    output cell_bit, collide
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
//
// Per-frame controller for the falling-block game. After a start edge it
// waits for a frame tick, then issues one player-move, one playfield-shift
// and (every SPAWN_PERIOD frames) one spawn strobe, samples the collision
// flag, and sweeps the whole playfield to the VGA plot port.
//
// Ports:
//   clock       in   system clock
//   resetn      in   synchronous, active-low reset
//   start       in   level; rising edge starts/restarts a game (IDLE/OVER only)
//   frame_tick  in   one-cycle pulse per frame (honoured in WAIT only)
//   left, right in   held player buttons
//   bus         --   game_sequencer_if.master: strobes, read address,
//                    cell_bit/collide inputs, plot/x/y/colour outputs
//   busy        out  high in every state except IDLE, WAIT and OVER
//   game_over   out  high in OVER
//   score       out  frames survived, saturating at 255
module game_sequencer #(
  parameter int         COLS         = 16,
  parameter int         ROWS         = 32,
  parameter int         SPAWN_PERIOD = 16,
  parameter logic [2:0] FG_COLOUR    = 3'b111,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                frame_tick,
  input  logic                left,
  input  logic                right,
  game_sequencer_if.master    bus,
  output logic                busy,
  output logic                game_over,
  output logic [7:0]          score
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  // A period of 1 still needs a one-bit counter that always reads 0.
  localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [SPAWN_W-1:0] LAST_SPAWN = SPAWN_W'(SPAWN_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MOVE,
    S_SHIFT,
    S_SPAWN,
    S_CHECK,
    S_DRAW,
    S_OVER
  } state_t;

  state_t             state_q,     state_d;
  logic               start_q,     start_d;
  logic [7:0]         score_q,     score_d;
  logic [SPAWN_W-1:0] spawn_cnt_q, spawn_cnt_d;
  logic               hit_q,       hit_d;
  logic [COL_W-1:0]   col_q,       col_d;
  logic [ROW_W-1:0]   row_q,       row_d;
  logic               flush_q,     flush_d;
  logic               plot_q,      plot_d;
  logic [COL_W-1:0]   x_q,         x_d;
  logic [ROW_W-1:0]   y_q,         y_d;

  logic start_edge;

  // A start held high only produces an edge on the cycle it first rises.
  assign start_edge = start & ~start_q;

  always_comb begin
    state_d     = state_q;
    start_d     = start;
    score_d     = score_q;
    spawn_cnt_d = spawn_cnt_q;
    hit_d       = hit_q;
    col_d       = col_q;
    row_d       = row_q;
    flush_d     = flush_q;
    plot_d      = 1'b0;
    x_d         = '0;
    y_d         = '0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          score_d     = '0;
          spawn_cnt_d = '0;
          hit_d       = 1'b0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (frame_tick) begin
          state_d = S_MOVE;
        end
      end

      S_MOVE: begin
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (spawn_cnt_q == LAST_SPAWN) begin
          spawn_cnt_d = '0;
          state_d     = S_SPAWN;
        end else begin
          spawn_cnt_d = spawn_cnt_q + 1'b1;
          state_d     = S_CHECK;
        end
      end

      S_SPAWN: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        hit_d   = bus.collide;
        state_d = S_DRAW;
      end

      S_DRAW: begin
        // The address presented this cycle is echoed as the plot coordinate
        // next cycle, lining up with the one-cycle playfield read latency.
        plot_d = ~flush_q;
        x_d    = flush_q ? '0 : col_q;
        y_d    = flush_q ? '0 : row_q;

        if (flush_q) begin
          // Final cycle: the last plot is on the port now; leave the sweep.
          flush_d = 1'b0;
          if (hit_q) begin
            state_d = S_OVER;
          end else begin
            score_d = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
            state_d = S_WAIT;
          end
        end else if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            // Address counters return to 0 so rd_col/rd_row rest at 0.
            row_d   = '0;
            flush_d = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      score_q     <= '0;
      spawn_cnt_q <= '0;
      hit_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      flush_q     <= 1'b0;
      plot_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      score_q     <= score_d;
      spawn_cnt_q <= spawn_cnt_d;
      hit_q       <= hit_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      plot_q      <= plot_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  // Strobes and status are decoded straight from the registered state.
  assign bus.player_move = (state_q == S_MOVE) & (left ^ right);
  assign bus.move_dir    = (state_q == S_MOVE) & right;
  assign bus.shift_en    = (state_q == S_SHIFT);
  assign bus.spawn_en    = (state_q == S_SPAWN);

  assign bus.rd_col = (state_q == S_DRAW) ? col_q : '0;
  assign bus.rd_row = (state_q == S_DRAW) ? row_q : '0;

  // cell_bit is the registered output of the playfield read, aligned with
  // plot_q, so the colour selects between two constants off flop outputs.
  assign bus.plot   = plot_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = plot_q ? (bus.cell_bit ? FG_COLOUR : BG_COLOUR) : 3'b000;

  assign busy      = (state_q == S_MOVE)  || (state_q == S_SHIFT) ||
                     (state_q == S_SPAWN) || (state_q == S_CHECK) ||
                     (state_q == S_DRAW);
  assign game_over = (state_q == S_OVER);
  assign score     = score_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Per-frame controller for the 16x32 falling-block game. It waits for a frame tick and then issues, in fixed order, the player-move, playfield-shift and periodic spawn strobes to the datapath. It then samples the collision flag and sweeps the whole playfield out to the VGA adapter as plot writes. It sits between the frame counter, the playfield/state datapath and the `vga_adapter` plot port, replacing free-running enables with one sequenced pass per frame.

## Interface

Parameters:
- COLS, 16, playfield columns; power of two
- ROWS, 32, playfield rows; power of two
- SPAWN_PERIOD, 16, frames between spawn strobes; must be ≥ 1
- FG_COLOUR, 3'b111, colour plotted for an occupied cell
- BG_COLOUR, 3'b000, colour plotted for an empty cell

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  level input; its rising edge starts or restarts a game
- frame_tick  in  1  one-cycle pulse per frame
- left, right  in  1  held player buttons, active-high
- collide  in  1  player/obstacle overlap flag; valid in CHECK
- cell_bit  in  1  playfield bit at (rd_col, rd_row) from the previous cycle; read latency is 1
- player_move  out  1  one-cycle strobe: move the player
- move_dir  out  1  direction of the move: 1 = right, 0 = left
- shift_en  out  1  one-cycle strobe: shift the playfield down one row
- spawn_en  out  1  one-cycle strobe: load the spawn buffer
- rd_col  out  log2(COLS)  playfield read column
- rd_row  out  log2(ROWS)  playfield read row
- plot, x, y, colour  out  1, log2(COLS), log2(ROWS), 3  VGA write port
- busy  out  1  high in every state except IDLE, WAIT and OVER
- game_over  out  1  high in OVER
- score  out  8  frames survived; saturates at 255

## Operation

Strobes, `busy` and `game_over` decode from the registered state. `plot`, `x`, `y` and `colour` are registered.

State machine:
- **IDLE**
  - All outputs are 0.
  - Start edge: clear score, spawn counter and hit flag; go to WAIT.
- **WAIT**
  - frame_tick: go to MOVE.
  - No tick: stay.
- **MOVE** (1 cycle)
  - player_move = left XOR right; move_dir = right.
  - Both or neither button: no strobe.
  - Go to SHIFT.
- **SHIFT** (1 cycle)
  - shift_en = 1.
  - If spawn counter = SPAWN_PERIOD-1: counter wraps to 0, go to SPAWN.
  - Otherwise: counter increments, go to CHECK.
- **SPAWN** (1 cycle)
  - spawn_en = 1; go to CHECK.
- **CHECK** (1 cycle)
  - hit flag <= collide; go to DRAW.
- **DRAW**
  - rd_row/rd_col step row-major (column inner) from (0,0) to (COLS-1, ROWS-1): COLS*ROWS cycles.
  - Each address is echoed one cycle later on x/y with plot = 1; colour = cell_bit ? FG_COLOUR : BG_COLOUR.
  - One flush cycle follows the last address, so the state lasts COLS*ROWS+1 cycles.
  - Exit with hit set: go to OVER.
  - Exit without hit: score = min(score+1, 255), go to WAIT.
- **OVER**
  - game_over = 1; score holds.
  - Start edge: clear score, counter and flag as in IDLE; go to WAIT.

Start edge detection:
- A 1-cycle registered delay of `start` detects the edge.
- A `start` held high never retriggers.
- A start edge outside IDLE/OVER is ignored.

Boundary conditions:
- frame_tick outside WAIT is dropped, not queued.
- A tick in the same cycle as the DRAW→WAIT transition is also dropped.
- SPAWN_PERIOD = 1: SPAWN is taken every frame.
- rd_col/rd_row are 0 outside DRAW.
- Score at 255 stays at 255.

## Timing

- Reset sampled low at edge t: from t+1, state = IDLE and every output, the score and all counters are 0. This applies mid-DRAW too; any pending plot is discarded.
- Tick seen in WAIT at edge t:
  - player_move in cycle t+1
  - shift_en in t+2
  - spawn_en in t+3 if due
  - CHECK in t+3 (no spawn) or t+4 (spawn)
- DRAW entered at cycle d:
  - First address at d; first plot at d+1.
  - Last plot at d+COLS*ROWS.
  - WAIT/OVER at d+COLS*ROWS+1.
- Frame period must exceed COLS*ROWS+6 cycles (518 at defaults); otherwise frames are skipped.

## Test plan

- **Reset and start:** reset, then pulse start → WAIT; score=0, busy=0. Holding start high for 100 cycles does not retrigger.
- **One frame, right held, no spawn:** tick → player_move=1, move_dir=1 at t+1; shift_en at t+2; no spawn_en; 512 plots with x,y covering (0,0)…(15,31) in row-major order; score=1.
- **Spawn cadence:** with SPAWN_PERIOD=16, run 32 ticks → spawn_en exactly in frames 16 and 32.
- **Readback colour:** cell_bit driven as (rd_col==3 && rd_row==7) → exactly one plot with colour=3'b111, at x=3, y=7; all other plots 3'b000.
- **Collision:** collide=1 in CHECK of frame 5 → full draw completes, then game_over=1; score=4; further ticks ignored; a start edge returns to WAIT with score=0.
- **Reset mid-DRAW and tick overlap:** resetn low at address 200 → plot=0 and state IDLE on the next cycle. Separately, a tick during DRAW → no extra frame, score increments by 1.
